modular_subtractor: RTL and testbench

- Single-cycle-latency modular subtractor for the RNS/NTT datapath.
- Computes c = (a − b) mod q, where q is one of 13 fixed 30-bit NTT-friendly primes.
- The active q is held in an internal modulus register, loaded from a constant table when mod_sel is asserted.
- Used wherever butterfly/accumulate stages need a modular difference.

---
 rtl/modarith_pkg.sv | 30 +++
 rtl/modulus_rom.sv | 21 ++
 rtl/modular_subtractor.sv | 59 +++++
 tb/tb_modular_subtractor.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/modarith_pkg.sv
// rtl/modarith_pkg.sv - shared constants and modulus table for the modular arithmetic blocks
package modarith_pkg;

   // Operand, modulus and result width in bits.
   localparam int WIDTH      = 30;
   // Number of valid entries in the modulus table.
   localparam int NUM_MODULI = 13;
   // Width of the modulus table index.
   localparam int IDX_WIDTH  = 4;

   typedef logic [WIDTH-1:0]     residue_t;
   typedef logic [IDX_WIDTH-1:0] mod_index_t;

   // 30-bit NTT-friendly primes, selected by mod_index 0..12.
   localparam residue_t MODULUS_TABLE [0:NUM_MODULI-1] = '{
      30'd1063321601, 30'd1063452673, 30'd1064697857, 30'd1065484289,
      30'd1065811969, 30'd1068236801, 30'd1068433409, 30'd1068564481,
      30'd1069219841, 30'd1070727169, 30'd1071513601, 30'd1072496641,
      30'd1073479681
   };

   // Modulus in force straight out of reset.
   localparam residue_t RESET_MODULUS = MODULUS_TABLE[0];

   // True when idx addresses a populated table entry.
   function automatic logic index_in_range(input mod_index_t idx);
      return (idx < IDX_WIDTH'(NUM_MODULI));
   endfunction

endpackage

// File: rtl/modulus_rom.sv
// rtl/modulus_rom.sv - combinational modulus table lookup with out-of-range flag
module modulus_rom
   import modarith_pkg::*;
(
   input  logic [IDX_WIDTH-1:0] index,
   output logic [WIDTH-1:0]     q,
   output logic                 out_of_range
);

   // Decode the index against every table entry; unused codes return zero and raise the flag.
   always_comb begin
      q            = '0;
      out_of_range = !index_in_range(index);
      for (int i = 0; i < NUM_MODULI; i++) begin
         if (index == IDX_WIDTH'(i)) begin
            q = MODULUS_TABLE[i];
         end
      end
   end

endmodule

// File: rtl/modular_subtractor.sv
// rtl/modular_subtractor.sv - registered c = (a - b) mod q with a selectable prime modulus
module modular_subtractor
   import modarith_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mod_sel,
   input  logic [IDX_WIDTH-1:0] mod_index,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [WIDTH-1:0]     c
);

   logic [WIDTH-1:0] modulus;
   logic [WIDTH-1:0] rom_q;
   logic             rom_out_of_range;
   logic             load_modulus;

   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] corrected;
   logic [WIDTH-1:0] c_next;

   modulus_rom u_modulus_rom (
      .index        (mod_index),
      .q            (rom_q),
      .out_of_range (rom_out_of_range)
   );

   // Unpopulated indices are ignored so a bad select can never corrupt the modulus.
   assign load_modulus = mod_sel && !rom_out_of_range;

   // Modulus register: the new value only takes part in arithmetic from the following edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         modulus <= RESET_MODULUS;
      end else if (load_modulus) begin
         modulus <= rom_q;
      end
   end

   // One extra bit on the difference exposes the borrow; a borrow means add q back once.
   always_comb begin
      diff      = {1'b0, a} - {1'b0, b};
      borrow    = diff[WIDTH];
      corrected = diff[WIDTH-1:0] + modulus;
      c_next    = borrow ? corrected : diff[WIDTH-1:0];
   end

   // Output register: the only path from inputs to c, giving one cycle of latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c <= '0;
      end else begin
         c <= c_next;
      end
   end

endmodule

// File: tb/tb_modular_subtractor.sv
// tb/tb_modular_subtractor.sv - scoreboard bench for modular_subtractor against a reference model
module tb_modular_subtractor;

   logic        clk = 1'b0;
   logic        rst;
   logic        mod_sel;
   logic [3:0]  mod_index;
   logic [29:0] a;
   logic [29:0] b;
   logic [29:0] c;

   typedef struct {
      logic [29:0] exp;
      int          tag;
   } entry_t;

   entry_t sb[$];
   int tests = 0;
   int fails = 0;

   string names [0:9] = '{"basic", "wrap", "cross", "borrow", "zero",
                          "load_old_q", "load_new_q", "invalid_idx", "random", "after_reset"};

   int unsigned tbl [0:12] = '{
      1063321601, 1063452673, 1064697857, 1065484289, 1065811969,
      1068236801, 1068433409, 1068564481, 1069219841, 1070727169,
      1071513601, 1072496641, 1073479681
   };

   int unsigned q_model;

   modular_subtractor dut (
      .clk       (clk),
      .rst       (rst),
      .mod_sel   (mod_sel),
      .mod_index (mod_index),
      .a         (a),
      .b         (b),
      .c         (c)
   );

   always #5 clk = ~clk;

   // Monitor: every result is available half a cycle after the edge that produced it.
   always @(negedge clk) begin
      entry_t e;
      if (!rst && sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (c !== e.exp) begin
            fails++;
            $display("FAIL %s: c=%0d expected %0d", names[e.tag], c, e.exp);
         end
      end
   end

   // Apply one cycle of stimulus and queue the reference result for it.
   task automatic drive(input int unsigned ta, input int unsigned tb_v, input logic sel,
                        input int unsigned idx, input int tag,
                        input bit fixed, input int unsigned fval);
      longint d;
      entry_t e;
      @(negedge clk);
      a         = ta[29:0];
      b         = tb_v[29:0];
      mod_sel   = sel;
      mod_index = idx[3:0];
      d = longint'(ta) - longint'(tb_v);
      if (d < 0) d = d + longint'(q_model);
      e.exp = fixed ? fval[29:0] : d[29:0];
      e.tag = tag;
      if (sel && idx <= 12) q_model = tbl[idx];
      @(posedge clk);
      sb.push_back(e);
   endtask

   task automatic set_mod(input int unsigned idx);
      drive(0, 0, 1'b1, idx, 4, 1'b1, 0);
   endtask

   initial begin
      rst = 1'b1; mod_sel = 1'b0; mod_index = '0; a = '0; b = '0;
      q_model = tbl[0];
      #12;
      tests++;
      if (c !== 30'd0) begin fails++; $display("FAIL reset_init: c=%0d expected 0", c); end
      @(negedge clk);
      rst = 1'b0;

      drive(100, 23, 1'b0, 0, 0, 1'b1, 77);
      drive(0, 0, 1'b0, 0, 4, 1'b1, 0);
      drive(12345, 12345, 1'b0, 0, 4, 1'b1, 0);
      drive(9354, 1239384, 1'b0, 0, 3, 1'b1, 1062091571);
      drive(1, tbl[0] - 1, 1'b0, 0, 1, 1'b1, 2);
      drive(0, tbl[0] - 1, 1'b0, 0, 1, 1'b1, 1);
      drive(1, 1073479680, 1'b0, 0, 2, 1'b1, 1063583746);

      for (int i = 0; i < 13; i++) begin
         set_mod(i);
         drive(1, tbl[i] - 1, 1'b0, 0, 1, 1'b1, 2);
      end
      drive(9354, 1239384, 1'b0, 0, 3, 1'b1, 1072249651);

      for (int i = 0; i < 13; i++) begin
         set_mod(i);
         for (int j = 0; j < 13; j++) drive(1, tbl[j] - 1, 1'b0, 0, 2, 1'b0, 0);
      end

      set_mod(5);
      drive(1, tbl[5] - 1, 1'b1, 12, 5, 1'b1, 2);
      drive(1, tbl[12] - 1, 1'b0, 0, 6, 1'b1, 2);
      drive(1, tbl[12] - 1, 1'b1, 13, 7, 1'b1, 2);
      drive(1, tbl[12] - 1, 1'b0, 0, 7, 1'b1, 2);
      drive(1, tbl[12] - 1, 1'b1, 15, 7, 1'b1, 2);
      drive(1, tbl[12] - 1, 1'b0, 0, 7, 1'b1, 2);

      for (int n = 0; n < 300; n++) begin
         drive($urandom_range(q_model - 1, 0), $urandom_range(q_model - 1, 0),
               ($urandom_range(0, 7) == 0), $urandom_range(0, 15), 8, 1'b0, 0);
      end

      set_mod(7);
      drive(500, 3, 1'b0, 0, 0, 1'b1, 497);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (c !== 30'd0) begin fails++; $display("FAIL reset_async: c=%0d expected 0", c); end
      q_model = tbl[0];
      @(negedge clk);
      rst = 1'b0;
      drive(100, 23, 1'b0, 0, 9, 1'b1, 77);
      drive(1, tbl[0] - 1, 1'b0, 0, 9, 1'b1, 2);
      drive(0, tbl[0] - 1, 1'b0, 0, 9, 1'b1, 1);

      @(negedge clk);
      @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
